// File: rtl/pr_constants_pkg.sv
// pr_constants: shared constants and state type for the PageRank AXI read arbiter
package pr_constants;
    localparam logic [2:0] ARSIZE_64B = 3'b110;
    localparam int REQ_VERT = 0;
    localparam int REQ_INEDGE = 1;
    localparam int REQ_RANK = 2;
    localparam int RIDX_W = 3;
    typedef enum logic {ST_IDLE, ST_ISSUE} arb_state_t;
endpackage

// File: rtl/pr_rr_pick.sv
// pr_rr_pick: combinational round-robin picker, first eligible index at or above ptr (mod N)
module pr_rr_pick
    import pr_constants::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]      elig,
    input  logic [RIDX_W-1:0] ptr,
    output logic [RIDX_W-1:0] gnt,
    output logic              any
);
    // Scan farthest-first so the nearest eligible index from ptr wins last
    always_comb begin
        gnt = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (elig[(int'(ptr) + k) % N]) gnt = RIDX_W'((int'(ptr) + k) % N);
        end
    end
    assign any = |elig;
endmodule

// File: rtl/pr_axi_rd_arbiter.sv
// pr_axi_rd_arbiter: shares one AXI AR/R master among NREQ read engines,
// round-robin AR arbitration with per-requester outstanding-burst limits and rid-based R routing.
module pr_axi_rd_arbiter
    import pr_constants::*;
#(
    parameter int NREQ = 3,
    parameter int MAX_OUT = 4,
    parameter int IDW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_arvalid,
    input  logic [NREQ*64-1:0] req_araddr,
    input  logic [NREQ*8-1:0] req_arlen,
    output logic [NREQ-1:0]   req_arready,
    output logic [NREQ-1:0]   req_rvalid,
    input  logic [NREQ-1:0]   req_rready,
    output logic [511:0]      req_rdata,
    output logic              req_rlast,
    output logic [IDW-1:0]    arid_m,
    output logic [63:0]       araddr_m,
    output logic [7:0]        arlen_m,
    output logic [2:0]        arsize_m,
    output logic              arvalid_m,
    input  logic              arready_m,
    input  logic [IDW-1:0]    rid_m,
    input  logic [511:0]      rdata_m,
    input  logic [1:0]        rresp_m,
    input  logic              rlast_m,
    input  logic              rvalid_m,
    output logic              rready_m,
    output logic              err,
    output logic              busy
);
    localparam int CW = $clog2(MAX_OUT + 1);

    arb_state_t        state_q, state_d;
    logic [RIDX_W-1:0] ptr_q, ptr_d, gnt_q, gnt_d, pick, ridx;
    logic [IDW-1:0]    arid_q, arid_d;
    logic [63:0]       araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [CW-1:0]     out_cnt_q [NREQ];
    logic [CW-1:0]     out_cnt_d [NREQ];
    logic              err_q, err_d;
    logic [NREQ-1:0]   elig, cnt_nz;
    logic [7:0]        rready_ext;
    logic              any, ar_fire, rid_ok, beat_acc, last_acc, spurious;

    pr_rr_pick #(.N(NREQ)) u_pick (.elig(elig), .ptr(ptr_q), .gnt(pick), .any(any));

    assign ridx     = rid_m[RIDX_W-1:0];
    assign rid_ok   = int'(ridx) < NREQ;
    assign ar_fire  = state_q == ST_ISSUE && arready_m;
    assign beat_acc = rvalid_m && rready_m;
    assign last_acc = beat_acc && rlast_m && rid_ok;

    // Out-of-range rids see a permanently ready slot, so their beats are drained
    always_comb begin
        rready_ext = '1;
        rready_ext[NREQ-1:0] = req_rready;
    end
    assign rready_m = rready_ext[ridx];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i]        = req_arvalid[i] && out_cnt_q[i] < CW'(MAX_OUT);
            cnt_nz[i]      = out_cnt_q[i] != '0;
            req_rvalid[i]  = rvalid_m && rid_ok && int'(ridx) == i;
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) req_arready[i] = state_q == ST_IDLE && any && int'(pick) == i;
    end

    // A burst issued and another completed for the same requester in one cycle cancel out
    always_comb begin
        spurious = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            out_cnt_d[i] = out_cnt_q[i];
            if (ar_fire && int'(gnt_q) == i && !(last_acc && int'(ridx) == i))
                out_cnt_d[i] = out_cnt_q[i] + CW'(1);
            else if (last_acc && int'(ridx) == i && !(ar_fire && int'(gnt_q) == i)) begin
                if (out_cnt_q[i] != '0) out_cnt_d[i] = out_cnt_q[i] - CW'(1);
                else spurious = 1'b1;
            end
        end
        err_d = err_q || spurious || (beat_acc && (!rid_ok || rresp_m != 2'b00));
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        arid_d   = arid_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        if (state_q == ST_IDLE) begin
            if (any) begin
                state_d  = ST_ISSUE;
                gnt_d    = pick;
                arid_d   = IDW'(pick);
                araddr_d = req_araddr[64*int'(pick) +: 64];
                arlen_d  = req_arlen[8*int'(pick) +: 8];
            end
        end else if (arready_m) begin
            state_d = ST_IDLE;
            ptr_d   = int'(gnt_q) == NREQ - 1 ? '0 : gnt_q + RIDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            arid_q   <= '0;
            araddr_q <= '0;
            arlen_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < NREQ; i++) out_cnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            arid_q   <= arid_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            err_q    <= err_d;
            for (int i = 0; i < NREQ; i++) out_cnt_q[i] <= out_cnt_d[i];
        end
    end

    assign arvalid_m = state_q == ST_ISSUE;
    assign arid_m    = arid_q;
    assign araddr_m  = araddr_q;
    assign arlen_m   = arlen_q;
    assign arsize_m  = ARSIZE_64B;
    assign req_rdata = rdata_m;
    assign req_rlast = rlast_m;
    assign err       = err_q;
    assign busy      = arvalid_m || |cnt_nz;
endmodule

// File: doc/pr_axi_rd_arbiter.md
Name: pr_axi_rd_arbiter

Overview:
- Shares the single PageRank AXI read master (AR/R channels) between NREQ internal read engines, e.g. the vertex reader, the in-edge reader and the rank-array reader.
- Arbitrates AR requests round-robin and tags each burst's arid with the requester index.
- Routes returning R beats to their owner by rid.
- Limits outstanding bursts per requester.
- Sits between the PageRank engines and the top-level arid_m/araddr_m/... ports.

Parameters:
- NREQ, 3, number of requesters (2..8).
- MAX_OUT, 4, maximum outstanding bursts per requester.
- IDW, 16, AXI ID width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_arvalid  in  NREQ  per-requester read request valid
- req_araddr  in  NREQ*64  byte addresses, requester i at [64i+63:64i]
- req_arlen  in  NREQ*8  burst lengths minus 1
- req_arready  out  NREQ  request accepted (captured) by arbiter
- req_rvalid  out  NREQ  data beat valid for requester i
- req_rready  in  NREQ  requester i accepts beat
- req_rdata  out  512  shared beat data (rdata_m passthrough)
- req_rlast  out  1  shared last flag (rlast_m passthrough)
- arid_m  out  IDW  AXI read ID
- araddr_m  out  64  AXI read address
- arlen_m  out  8  AXI burst length
- arsize_m  out  3  constant 3'b110 (64-byte beats)
- arvalid_m  out  1  AXI AR valid
- arready_m  in  1  AXI AR ready
- rid_m  in  IDW  returning ID
- rdata_m  in  512  returning data
- rresp_m  in  2  returning response (ignored except err)
- rlast_m  in  1  last beat
- rvalid_m  in  1  R valid
- rready_m  out  1  R ready
- err  out  1  sticky: bad rid or nonzero rresp seen
- busy  out  1  any burst outstanding or AR pending

Behaviour:
- Reset: state=IDLE, arvalid_m=0, araddr_m=0, arlen_m=0, arid_m=0, RR pointer=0, all outstanding counters=0, err=0, req_arready=0.
- Eligible(i) = req_arvalid[i] && out_cnt[i] < MAX_OUT.
- IDLE:
  - If any requester is eligible, pick the first eligible index searching from ptr upward, modulo NREQ.
  - req_arready[g] is combinational, high that cycle only. The request is captured into araddr_m/arlen_m, and arid_m={0,g}.
  - Next state is ISSUE; arvalid_m=1 from the next cycle.
  - If no requester is eligible, stay in IDLE; all req_arready=0.
- ISSUE:
  - arvalid_m and address/len/id are held stable until arready_m.
  - On arvalid_m && arready_m: out_cnt[g]++, ptr=(g+1) mod NREQ, next state IDLE, arvalid_m=0.
  - Throughput is one AR per 2 cycles minimum; this is acceptable.
- R routing, combinational:
  - idx = rid_m[2:0]. If idx<NREQ: req_rvalid[idx]=rvalid_m, rready_m=req_rready[idx].
  - If idx>=NREQ: no req_rvalid; rready_m=1 (beat dropped); err set.
  - req_rdata=rdata_m, req_rlast=rlast_m always.
- Completion: on rvalid_m && rready_m && rlast_m with valid idx, out_cnt[idx]--.
- Same-cycle AR accept and rlast for the same requester: counter unchanged.
- Decrement at 0 (spurious rlast): counter stays 0, err set.
- rresp_m != 0 on an accepted beat: err set; the beat is still delivered.
- busy = (state==ISSUE) || any out_cnt != 0.
- Reset mid-burst: all state is cleared; in-flight R beats after reset hit counter 0 and set err. The top level must quiesce memory across reset.
- Counter width is clog2(MAX_OUT+1).

Decomposition:
- Shared package pr_constants: ARSIZE_64B=3'b110, REQ_VERT=0, REQ_INEDGE=1, REQ_RANK=2, RID index width 3.
- Sub-module pr_rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: eligible vector, ptr. Outputs: grant index, any.
  - Reusable by a future write-channel arbiter.

Test Plan:
- Single request: req0 araddr=0, arlen=3.
  - Expected: req_arready[0] pulses, next cycle arvalid_m=1, araddr_m=0, arlen_m=3, arid_m=0.
  - After 4 beats with rlast on the 4th, out_cnt[0]=0 and busy=0.
- Round-robin: all three requesters hold arvalid continuously.
  - Expected grant order 0,1,2,0,1,2; arid_m follows the same sequence.
- Backpressure: hold arready_m=0 for 5 cycles.
  - Expected: araddr_m/arlen_m/arid_m stable, arvalid_m stays 1, no new req_arready.
- Outstanding limit: req1 issues 4 bursts with no R returned.
  - Expected: 5th request not granted while req0/req2 still get grants.
  - After one rlast for rid=1, the 5th request is granted.
- R routing with backpressure: beats with rid=2 while req_rready[2]=0.
  - Expected: rready_m=0, req_rvalid=3'b100.
  - rid=5 beat: rready_m=1, err=1 next cycle.
- Simultaneous events: AR accept for req0 in the same cycle as rlast for rid=0 with out_cnt[0]=1.
  - Expected: out_cnt[0] remains 1.
  - Then assert rst for one cycle mid-burst: all outputs return to reset values.
